// File: rtl/jackpot_autoplayer.sv
// Automated jackpot player: watches the rotating LED ring and fires a timed
// switch press so the game's own switch latency lands it on the target LED.
module jackpot_autoplayer #(
  parameter int LEAD            = 1,
  parameter int PRESS_CYCLES    = 2,
  parameter int WIN_WINDOW      = 4,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int CNT_W           = 8
) (
  input  logic             out_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       target,
  input  logic [3:0]       leds,
  output logic [3:0]       switches,
  output logic             busy,
  output logic             win,
  output logic             jackpot,
  output logic [CNT_W-1:0] attempts,
  output logic [CNT_W-1:0] wins
);

  localparam int TMR_MAX0 = (PRESS_CYCLES > WIN_WINDOW) ? PRESS_CYCLES : WIN_WINDOW;
  localparam int TMR_MAX  = (TMR_MAX0 > COOLDOWN_CYCLES) ? TMR_MAX0 : COOLDOWN_CYCLES;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] PRESS_LAST = TMR_W'(PRESS_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LAST   = TMR_W'(WIN_WINDOW - 1);
  localparam logic [TMR_W-1:0] CD_LAST    = TMR_W'(COOLDOWN_CYCLES - 1);
  localparam logic [1:0]       LEAD_MOD   = 2'(LEAD % 4);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_PRESS,
    S_OBSERVE,
    S_COOLDOWN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       sw_q, sw_d;
  logic             win_q, win_d;
  logic             busy_q, jackpot_q;
  logic [CNT_W-1:0] att_q, att_d;
  logic [CNT_W-1:0] wins_q, wins_d;

  logic [1:0] aim;
  logic [3:0] aim_oh;
  logic [3:0] tgt_oh;
  logic       all_on;

  // Fire when the ring sits LEAD positions before the target.
  assign aim    = tgt_q - LEAD_MOD;
  assign aim_oh = 4'b0001 << aim;
  assign tgt_oh = 4'b0001 << tgt_q;
  assign all_on = (leds == 4'b1111);

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    tmr_d   = tmr_q;
    sw_d    = sw_q;
    win_d   = 1'b0;
    att_d   = att_q;
    wins_d  = wins_q;
    if (!enable) begin
      state_d = S_IDLE;
      sw_d    = 4'b0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ALIGN;
          tgt_d   = target;
        end
        S_ALIGN: begin
          if (all_on) begin
            state_d = S_DONE;
          end else if (leds == aim_oh) begin
            state_d = S_PRESS;
            sw_d    = tgt_oh;
            tmr_d   = '0;
            if (att_q != CNT_MAX) att_d = att_q + 1'b1;
          end
        end
        S_PRESS: begin
          if (all_on) begin
            state_d = S_DONE;
            sw_d    = 4'b0000;
            win_d   = 1'b1;
            if (wins_q != CNT_MAX) wins_d = wins_q + 1'b1;
          end else if (tmr_q == PRESS_LAST) begin
            state_d = S_OBSERVE;
            sw_d    = 4'b0000;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        S_OBSERVE: begin
          if (all_on) begin
            state_d = S_DONE;
            win_d   = 1'b1;
            if (wins_q != CNT_MAX) wins_d = wins_q + 1'b1;
          end else if (tmr_q == WIN_LAST) begin
            state_d = S_COOLDOWN;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        S_COOLDOWN: begin
          // Guaranteed low gap so the game sees a fresh rising edge next press.
          if (tmr_q == CD_LAST) begin
            state_d = S_ALIGN;
            tgt_d   = target;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        S_DONE: begin
          sw_d = 4'b0000;
        end
        default: begin
          state_d = S_IDLE;
          sw_d    = 4'b0000;
        end
      endcase
    end
  end

  always_ff @(posedge out_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tgt_q     <= 2'd0;
      tmr_q     <= '0;
      sw_q      <= 4'b0000;
      win_q     <= 1'b0;
      busy_q    <= 1'b0;
      jackpot_q <= 1'b0;
      att_q     <= '0;
      wins_q    <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      tmr_q     <= tmr_d;
      sw_q      <= sw_d;
      win_q     <= win_d;
      busy_q    <= (state_d != S_IDLE);
      jackpot_q <= (state_d == S_DONE);
      att_q     <= att_d;
      wins_q    <= wins_d;
    end
  end

  assign switches = sw_q;
  assign busy     = busy_q;
  assign win      = win_q;
  assign jackpot  = jackpot_q;
  assign attempts = att_q;
  assign wins     = wins_q;

endmodule

// File: tb/tb_jackpot_autoplayer.sv
// Randomised bench: stimulus predicts every output change (cycle + full output
// tuple) into a queue; an independent monitor pops on each observed change.
module tb_jackpot_autoplayer;

  localparam int LEAD = 1;
  localparam int PC   = 2;
  localparam int WW   = 4;
  localparam int CD   = 8;
  localparam int CW   = 2;

  typedef struct packed {
    logic [3:0]    sw;
    logic          busy;
    logic          win;
    logic          jp;
    logic [CW-1:0] att;
    logic [CW-1:0] wns;
  } tup_t;

  logic          out_clk = 1'b0;
  logic          reset   = 1'b1;
  logic          enable  = 1'b0;
  logic [1:0]    target  = 2'd0;
  logic [3:0]    leds    = 4'd0;
  logic [3:0]    switches;
  logic          busy, win, jackpot;
  logic [CW-1:0] attempts, wins;

  jackpot_autoplayer #(
    .LEAD(LEAD), .PRESS_CYCLES(PC), .WIN_WINDOW(WW), .COOLDOWN_CYCLES(CD), .CNT_W(CW)
  ) dut (
    .out_clk(out_clk), .reset(reset), .enable(enable), .target(target), .leds(leds),
    .switches(switches), .busy(busy), .win(win), .jackpot(jackpot),
    .attempts(attempts), .wins(wins)
  );

  always #5 out_clk = ~out_clk;

  int cyc = 0;
  always @(posedge out_clk) cyc <= cyc + 1;

  // Scoreboard
  int   cycq[$];
  tup_t tupq[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_on = 1'b0;
  int   mon_start = 0;
  bit   done_flag = 1'b0;

  // Reference model: expected output values after each edge
  logic [3:0]    m_sw;
  logic          m_busy, m_win, m_jp;
  logic [CW-1:0] m_att, m_wns;
  tup_t          last_push;
  bit            force_push = 1'b1;
  int            cur_tgt = 0;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (int'(v) >= (1 << CW) - 1) return v;
    return CW'(int'(v) + 1);
  endfunction

  function automatic logic [3:0] aim_oh();
    int a;
    a = ((cur_tgt - LEAD) % 4 + 4) % 4;
    return 4'(1 << a);
  endfunction

  function automatic logic [3:0] align_noise();
    logic [3:0] v;
    do v = 4'($urandom); while (v == aim_oh() || v == 4'hF);
    return v;
  endfunction

  function automatic logic [3:0] not_full();
    logic [3:0] v;
    do v = 4'($urandom); while (v == 4'hF);
    return v;
  endfunction

  task automatic step();
    @(negedge out_clk);
  endtask

  task automatic expect_at(input int c);
    tup_t t;
    t = '{m_sw, m_busy, m_win, m_jp, m_att, m_wns};
    if (force_push || t != last_push) begin
      cycq.push_back(c);
      tupq.push_back(t);
      last_push  = t;
      force_push = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    reset  = 1'b1;
    enable = 1'b0;
    m_sw = 4'd0; m_busy = 1'b0; m_win = 1'b0; m_jp = 1'b0; m_att = '0; m_wns = '0;
    expect_at(cyc + 1);
    repeat (n) begin
      leds   = 4'($urandom);
      target = 2'($urandom);
      step();
    end
    reset = 1'b0;
  endtask

  task automatic do_enable(input int t);
    enable  = 1'b1;
    target  = (t < 0) ? 2'($urandom) : 2'(t);
    cur_tgt = int'(target);
    leds    = 4'($urandom);
    m_busy  = 1'b1;
    expect_at(cyc + 1);
    step();
  endtask

  task automatic do_disable();
    enable = 1'b0;
    m_sw = 4'd0; m_busy = 1'b0; m_jp = 1'b0; m_win = 1'b0;
    expect_at(cyc + 1);
    step();
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) begin
      leds   = 4'($urandom);
      target = 2'($urandom);
      step();
    end
  endtask

  task automatic hold_done();
    repeat ($urandom_range(1, 4)) begin
      leds   = 4'($urandom);
      target = 2'($urandom);
      step();
    end
  endtask

  // Next edge is in ALIGN; returns the edge at which the press appears.
  task automatic press(output int e0);
    repeat ($urandom_range(0, 3)) begin
      leds   = align_noise();
      target = 2'($urandom);
      step();
    end
    leds   = aim_oh();
    target = 2'($urandom);
    e0     = cyc + 1;
    m_sw   = 4'(1 << cur_tgt);
    m_att  = sat_inc(m_att);
    expect_at(e0);
    step();
  endtask

  task automatic attempt_miss();
    int e0;
    press(e0);
    for (int i = 1; i <= PC + WW + CD; i++) begin
      target = 2'($urandom);
      leds   = (i <= PC + WW) ? not_full() : 4'($urandom);
      if (i == PC) begin
        m_sw = 4'd0;
        expect_at(e0 + i);
      end
      if (i == PC + WW + CD) cur_tgt = int'(target);
      step();
    end
  endtask

  task automatic attempt_hit();
    int e0, j;
    press(e0);
    j = $urandom_range(1, PC + WW);
    for (int i = 1; i <= j; i++) begin
      target = 2'($urandom);
      leds   = (i == j) ? 4'hF : not_full();
      if (i == j) begin
        m_sw = 4'd0; m_win = 1'b1; m_jp = 1'b1; m_wns = sat_inc(m_wns);
        expect_at(e0 + i);
      end else if (i == PC) begin
        m_sw = 4'd0;
        expect_at(e0 + i);
      end
      step();
    end
    m_win = 1'b0;
    expect_at(e0 + j + 1);
    hold_done();
    do_disable();
    gap();
    do_enable(-1);
  endtask

  // Drop enable mid-attempt while the ring shows 1111: must not count a win.
  task automatic attempt_abort();
    int e0, a;
    press(e0);
    a = $urandom_range(1, PC + WW);
    for (int i = 1; i < a; i++) begin
      leds = not_full();
      if (i == PC) begin
        m_sw = 4'd0;
        expect_at(e0 + i);
      end
      step();
    end
    leds   = 4'hF;
    enable = 1'b0;
    m_sw = 4'd0; m_busy = 1'b0;
    expect_at(e0 + a);
    step();
    gap();
    do_enable(-1);
  endtask

  task automatic already_won();
    leds = 4'hF;
    m_jp = 1'b1;
    expect_at(cyc + 1);
    step();
    hold_done();
    do_disable();
    gap();
    do_enable(-1);
  endtask

  task automatic mid_reset();
    int e0, a;
    press(e0);
    a = $urandom_range(1, PC + WW);
    for (int i = 1; i < a; i++) begin
      leds = not_full();
      if (i == PC) begin
        m_sw = 4'd0;
        expect_at(e0 + i);
      end
      step();
    end
    do_reset($urandom_range(1, 2));
    do_enable(-1);
  endtask

  task automatic run_action(input int code);
    case (code)
      0: attempt_miss();
      1: attempt_hit();
      2: attempt_abort();
      3: already_won();
      default: mid_reset();
    endcase
  endtask

  // Stimulus
  initial begin
    int seq0[10] = '{0, 0, 0, 0, 0, 1, 2, 3, 4, 0};
    mon_start = 1;
    mon_on    = 1'b1;
    do_reset(2);
    do_enable(2);
    foreach (seq0[k]) run_action(seq0[k]);
    repeat (6) begin
      do_reset($urandom_range(1, 2));
      do_enable(-1);
      repeat ($urandom_range(3, 8)) run_action($urandom_range(0, 4));
    end
    do_disable();
    repeat (3) step();
    done_flag = 1'b1;
  end

  // Monitor
  tup_t cur, prev, et;
  int   ec;
  bit   first = 1'b1;
  initial begin
    prev = '0;
    forever begin
      @(negedge out_clk);
      if (mon_on && cyc >= mon_start) begin
        cur = '{switches, busy, win, jackpot, attempts, wins};
        if (first || cur != prev) begin
          checks++;
          if (cycq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur);
          end else begin
            ec = cycq.pop_front();
            et = tupq.pop_front();
            if (ec != cyc || et != cur) begin
              errors++;
              $display("FAIL event cyc got=%0d required=%0d tuple got=%h required=%h",
                       cyc, ec, cur, et);
            end else begin
              $display("evt cyc=%0d sw=%b busy=%b win=%b jp=%b att=%0d wins=%0d",
                       cyc, cur.sw, cur.busy, cur.win, cur.jp, cur.att, cur.wns);
            end
          end
          first = 1'b0;
        end else if (cycq.size() > 0 && cycq[0] <= cyc) begin
          checks++;
          errors++;
          ec = cycq.pop_front();
          et = tupq.pop_front();
          $display("FAIL missing_event cyc=%0d got=%h required=%h", ec, cur, et);
        end
        prev = cur;
        if (done_flag) begin
          checks++;
          if (cycq.size() != 0) begin
            errors++;
            $display("FAIL leftover_events got=%0d required=0", cycq.size());
          end
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $finish;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jackpot_autoplayer.md
Name: jackpot_autoplayer

Overview:
- Automated player for the jackpot LED game: watches the rotating 4-bit LED ring and drives the 4 switch lines with timed presses aimed at a selected position.
- Sits on the switch side of the game, acting as the opposite end of its LED/switch interface.
- Used as a demo/attract-mode opponent and as a closed-loop stimulus source for the game.
- Tracks attempts and wins.

Parameters:
- LEAD, 1: ring positions (clock cycles) to fire ahead of the target, compensating for switch-path latency.
- PRESS_CYCLES, 2: cycles a press is held high (>=1).
- WIN_WINDOW, 4: cycles after release in which LEDS==4'b1111 counts as a win (>=1).
- COOLDOWN_CYCLES, 8: forced all-low gap after a miss before re-aiming (>=1).
- CNT_W, 8: width of the attempt and win counters.

Ports:
- out_clk, input, 1: game clock (divided clock).
- reset, input, 1: synchronous, active-high.
- enable, input, 1: play while high.
- target, input, 2: LED index to hit; latched on entry to ALIGN.
- leds, input, 4: game LED ring.
- switches, output, 4: switch drive, registered.
- busy, output, 1: high in every state except IDLE.
- win, output, 1: one-cycle pulse on a detected jackpot caused by own press.
- jackpot, output, 1: level; high while in DONE.
- attempts, output, CNT_W: presses issued, saturating.
- wins, output, CNT_W: wins detected, saturating.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock out_clk.
- All state and outputs are registered and update on posedge out_clk.
- Reset: state=IDLE; switches=0, busy=0, win=0, jackpot=0, attempts=0, wins=0. Reset mid-press forces switches=0 at the next edge.
- Align position: aim = (tgt_q - LEAD) mod 4. Match means leds == one-hot(aim).
- IDLE:
  - enable=1 -> ALIGN; tgt_q<=target.
- ALIGN:
  - leds==4'b1111 -> DONE. No press, no win pulse, attempts unchanged.
  - Else if match -> PRESS. switches<=one-hot(tgt_q) at the same edge; attempts+=1.
  - Other patterns (0000, multi-hot) are ignored.
- PRESS:
  - switches held for exactly PRESS_CYCLES cycles, counting the entry cycle. Then switches<=0 -> OBSERVE, window counter cleared.
  - leds==4'b1111 during PRESS -> switches<=0, win pulse, wins+=1 -> DONE.
- OBSERVE:
  - leds==4'b1111 in any of WIN_WINDOW cycles -> win=1 for that cycle, wins+=1 -> DONE.
  - Window expires -> COOLDOWN.
- COOLDOWN:
  - switches=0 for COOLDOWN_CYCLES cycles -> ALIGN; tgt_q re-latched from target.
- DONE:
  - jackpot=1, switches=0. Held until enable=0 or reset.
  - enable=0 -> IDLE, jackpot cleared.
- enable=0 in any non-IDLE state -> IDLE at the next edge.
  - switches=0 from that edge.
  - No win pulse, no counter increment on that edge.
  - Counters retained.
- A target change while busy is ignored until the next tgt_q latch.
- Counters saturate at 2^CNT_W-1; no wrap.
- Only one switch bit is ever high at a time.
- Minimum low time between presses is COOLDOWN_CYCLES, so the game's edge detection sees a fresh rising edge.

Test Plan:
1. Reset: assert reset 2 cycles with arbitrary leds -> switches=0, busy=0, win=0, jackpot=0, attempts=0, wins=0.
2. Hit: enable=1, target=2, LEAD=1, ring model 0001->0010 -> at edge sampling 0010, switches=0100 for exactly 2 cycles, attempts=1. Model then drives 1111 -> one-cycle win, wins=1, jackpot=1, switches=0, stays in DONE.
3. Miss: ring model never reaches 1111 -> after release, 4 window cycles, then 8 cycles with switches=0. Next press aims again and attempts=2, wins=0.
4. Abort: drop enable during the 2nd PRESS cycle -> switches=0 and busy=0 on the next edge, attempts=1 retained. Re-enable -> fresh alignment.
5. Saturation: CNT_W=2, force 5 misses -> attempts stays 3, wins=0.
6. Already won: enable with leds=1111 -> DONE, jackpot=1, win never pulses, attempts=0. Deassert enable -> jackpot=0, IDLE.
